// File: rtl/rename_wide.sv
// Multi-lane register rename stage: RAT lookup with intra-group bypass, free-pool
// allocation, retire frees, and a registered valid/ready output stage. Optional
// single checkpoint is enabled by defining RENAME_CKPT_EN.
module rename_wide #(
  parameter int NUM_REG  = 32,
  parameter int NUM_TAGS = 64,
  parameter int WIDTH    = 2,
  localparam int RL = $clog2(NUM_REG),
  localparam int TL = $clog2(NUM_TAGS)
) (
  input  logic                clk,
  input  logic                rst,
`ifdef RENAME_CKPT_EN
  input  logic                ckpt_take,
  input  logic                ckpt_restore,
`endif
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [WIDTH-1:0]    in_lane_valid,
  input  logic [WIDTH*RL-1:0] in_rd,
  input  logic [WIDTH*RL-1:0] in_rs1,
  input  logic [WIDTH*RL-1:0] in_rs2,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [WIDTH-1:0]    out_lane_valid,
  output logic [WIDTH*TL-1:0] out_tag_rd,
  output logic [WIDTH*TL-1:0] out_tag_rs1,
  output logic [WIDTH*TL-1:0] out_tag_rs2,
  output logic [WIDTH*TL-1:0] out_old_rd,
  input  logic [WIDTH-1:0]    retire_valid,
  input  logic [WIDTH*TL-1:0] retire_tag,
  output logic [TL:0]         free_count
);

  localparam logic [NUM_TAGS-1:0] RESET_FREE = {{(NUM_TAGS-NUM_REG){1'b1}}, {NUM_REG{1'b0}}};
  localparam logic [TL:0]         WIDTH_T    = (TL+1)'(WIDTH);

  logic [TL-1:0]       rat      [NUM_REG];
  logic [TL-1:0]       rat_next [NUM_REG];
  logic [NUM_TAGS-1:0] free_pool, free_next, alloc_mask, retire_mask;
  logic [WIDTH-1:0]    alloc;
  logic [TL-1:0]       new_tag [WIDTH];
  logic [WIDTH*TL-1:0] tag_rd_d, tag_rs1_d, tag_rs2_d, old_rd_d;
  logic                fire, restore;

`ifdef RENAME_CKPT_EN
  logic [TL-1:0]       snap_rat [NUM_REG];
  logic [NUM_TAGS-1:0] snap_free, freed_since;
  assign restore = ckpt_restore;
`else
  assign restore = 1'b0;
`endif

  function automatic logic [TL:0] popcnt(input logic [NUM_TAGS-1:0] v);
    logic [TL:0] c;
    c = '0;
    for (int i = 0; i < NUM_TAGS; i++) c = c + {{TL{1'b0}}, v[i]};
    return c;
  endfunction

  // Handshakes: a transfer happens on a cycle where valid & ready are both high.
  // in_ready never looks at in_valid; out_valid holds its group until out_ready.
  assign in_ready = ~rst & ~restore & (~out_valid | out_ready) & (free_count >= WIDTH_T);
  assign fire     = in_valid & in_ready;

  // k-th allocating lane takes the k-th lowest free tag
  always_comb begin
    logic [NUM_TAGS-1:0] avail;
    avail      = free_pool;
    alloc_mask = '0;
    alloc      = '0;
    for (int i = 0; i < WIDTH; i++) new_tag[i] = '0;
    for (int i = 0; i < WIDTH; i++) begin
      alloc[i] = in_lane_valid[i] && (in_rd[i*RL +: RL] != '0);
      if (alloc[i]) begin
        for (int t = NUM_TAGS-1; t >= 0; t--) if (avail[t]) new_tag[i] = TL'(t);
        avail[new_tag[i]]      = 1'b0;
        alloc_mask[new_tag[i]] = 1'b1;
      end
    end
  end

  // Source/old-rd lookup: RAT value, overridden by the youngest older allocating lane
  always_comb begin
    logic [RL-1:0] rd_j, rs1_j, rs2_j;
    logic [TL-1:0] t1, t2, to;
    rd_j = '0; rs1_j = '0; rs2_j = '0;
    t1 = '0; t2 = '0; to = '0;
    tag_rd_d = '0; tag_rs1_d = '0; tag_rs2_d = '0; old_rd_d = '0;
    for (int j = 0; j < WIDTH; j++) begin
      rd_j  = in_rd[j*RL +: RL];
      rs1_j = in_rs1[j*RL +: RL];
      rs2_j = in_rs2[j*RL +: RL];
      t1 = rat[rs1_j];
      t2 = rat[rs2_j];
      to = rat[rd_j];
      for (int i = 0; i < j; i++) begin
        if (alloc[i]) begin
          if (in_rd[i*RL +: RL] == rs1_j) t1 = new_tag[i];
          if (in_rd[i*RL +: RL] == rs2_j) t2 = new_tag[i];
          if (in_rd[i*RL +: RL] == rd_j)  to = new_tag[i];
        end
      end
      if (rs1_j == '0) t1 = '0;
      if (rs2_j == '0) t2 = '0;
      tag_rs1_d[j*TL +: TL] = t1;
      tag_rs2_d[j*TL +: TL] = t2;
      if (alloc[j]) begin
        tag_rd_d[j*TL +: TL] = new_tag[j];
        old_rd_d[j*TL +: TL] = to;
      end
    end
  end

  // Younger lanes are written last so they win on a shared rd
  always_comb begin
    for (int k = 0; k < NUM_REG; k++) rat_next[k] = rat[k];
    if (fire) begin
      for (int i = 0; i < WIDTH; i++)
        if (alloc[i]) rat_next[in_rd[i*RL +: RL]] = new_tag[i];
    end
  end

  always_comb begin
    retire_mask = '0;
    for (int i = 0; i < WIDTH; i++)
      if (retire_valid[i]) retire_mask[retire_tag[i*TL +: TL]] = 1'b1;
    retire_mask[0] = 1'b0;
  end

  always_comb begin
    free_next = (free_pool & ~({NUM_TAGS{fire}} & alloc_mask)) | retire_mask;
`ifdef RENAME_CKPT_EN
    if (ckpt_restore) free_next = snap_free | freed_since | retire_mask;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < NUM_REG; k++) rat[k] <= TL'(k);
      free_pool  <= RESET_FREE;
      free_count <= (TL+1)'(NUM_TAGS - NUM_REG);
    end else begin
`ifdef RENAME_CKPT_EN
      if (ckpt_restore) begin
        for (int k = 0; k < NUM_REG; k++) rat[k] <= snap_rat[k];
      end else
`endif
      begin
        for (int k = 0; k < NUM_REG; k++) rat[k] <= rat_next[k];
      end
      free_pool  <= free_next;
      free_count <= popcnt(free_next);
    end
  end

`ifdef RENAME_CKPT_EN
  // A restore re-bases the checkpoint on the restored free pool
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < NUM_REG; k++) snap_rat[k] <= TL'(k);
      snap_free   <= RESET_FREE;
      freed_since <= '0;
    end else if (ckpt_restore) begin
      snap_free   <= snap_free | freed_since | retire_mask;
      freed_since <= '0;
    end else if (ckpt_take) begin
      for (int k = 0; k < NUM_REG; k++) snap_rat[k] <= rat_next[k];
      snap_free   <= free_next;
      freed_since <= '0;
    end else begin
      freed_since <= freed_since | retire_mask;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid      <= 1'b0;
      out_lane_valid <= '0;
      out_tag_rd     <= '0;
      out_tag_rs1    <= '0;
      out_tag_rs2    <= '0;
      out_old_rd     <= '0;
    end else if (restore) begin
      out_valid <= 1'b0;
    end else if (fire) begin
      out_valid      <= 1'b1;
      out_lane_valid <= in_lane_valid;
      out_tag_rd     <= tag_rd_d;
      out_tag_rs1    <= tag_rs1_d;
      out_tag_rs2    <= tag_rs2_d;
      out_old_rd     <= old_rd_d;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule
